// File: rtl/cache_axi_bridge.sv
// Cache refill/writeback port to AXI4 master bridge: independent read and write FSMs.
// Define CACHE_BRIDGE_RAW_ADDR_CMP_EN to limit read-after-write stalls to the pending line.
//
// state  | meaning
// R_IDLE | ready for a cache read request
// R_AR   | presenting read address
// R_DATA | passing R beats straight to the cache
// W_IDLE | write buffer free
// W_AW   | presenting write address
// W_DATA | streaming buffered words on W
// W_RESP | waiting for the B response
module cache_axi_bridge #(
    parameter logic [3:0] ID     = 4'd0,
    parameter int          ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd_req,
    input  logic [3:0]        rd_type,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic [1:0]        ret_last,
    output logic [31:0]       ret_data,
    input  logic              wr_req,
    input  logic [3:0]        wr_type,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [127:0]      wr_data,
    output logic              wr_rdy,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);
    localparam logic [3:0] TYPE_LINE = 4'd4;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

    rd_state_t         r_rd_state, w_rd_state_nxt;
    wr_state_t         r_wr_state, w_wr_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
    logic [3:0]        r_rd_type, r_wr_type, r_wr_strb;
    logic [127:0]      r_wr_buf;
    logic              r_wbuf_valid;
    logic [1:0]        r_cnt;
    logic              w_raw_block, w_rd_accept, w_wr_accept;
    logic              w_rd_line, w_wr_line;
    logic              w_unused;

    assign w_unused = ^{rid, rresp, bid, bresp};

    // Uses the buffer state before this cycle's write acceptance.
`ifdef CACHE_BRIDGE_RAW_ADDR_CMP_EN
    assign w_raw_block = r_wbuf_valid & (rd_addr[ADDR_W-1:4] == r_wr_addr[ADDR_W-1:4]);
`else
    assign w_raw_block = r_wbuf_valid;
`endif

    assign w_rd_line = (r_rd_type == TYPE_LINE);
    assign w_wr_line = (r_wr_type == TYPE_LINE);

    assign arid    = ID;
    assign araddr  = r_rd_addr;
    assign arlen   = w_rd_line ? 8'd3 : 8'd0;
    assign arsize  = w_rd_line ? 3'd2 : {1'b0, r_rd_type[1:0]};
    assign arburst = 2'b01;

    assign awid    = ID;
    assign wid     = ID;
    assign awaddr  = r_wr_addr;
    assign awlen   = w_wr_line ? 8'd3 : 8'd0;
    assign awsize  = w_wr_line ? 3'd2 : {1'b0, r_wr_type[1:0]};
    assign awburst = 2'b01;
    assign wdata   = r_wr_buf[{r_cnt, 5'b0} +: 32];
    assign wstrb   = w_wr_line ? 4'hf : r_wr_strb;

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_accept    = 1'b0;
        rd_rdy         = 1'b0;
        arvalid        = 1'b0;
        rready         = 1'b0;
        ret_valid      = 1'b0;
        ret_last       = 2'b00;
        ret_data       = rdata;
        case (r_rd_state)
            R_IDLE: begin
                rd_rdy      = ~w_raw_block;
                w_rd_accept = rd_req & ~w_raw_block;
                if (w_rd_accept) w_rd_state_nxt = R_AR;
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) w_rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                rready    = 1'b1;
                ret_valid = rvalid;
                ret_last  = {1'b0, rvalid & rlast};
                if (rvalid && rlast) w_rd_state_nxt = R_IDLE;
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_accept    = 1'b0;
        wr_rdy         = 1'b0;
        awvalid        = 1'b0;
        wvalid         = 1'b0;
        wlast          = 1'b0;
        bready         = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                wr_rdy      = 1'b1;
                w_wr_accept = wr_req;
                if (wr_req) w_wr_state_nxt = W_AW;
            end
            W_AW: begin
                awvalid = 1'b1;
                if (awready) w_wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = ({6'b0, r_cnt} == awlen);
                if (wready && wlast) w_wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_state   <= R_IDLE;
            r_wr_state   <= W_IDLE;
            r_wbuf_valid <= 1'b0;
            r_cnt        <= 2'd0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_wr_state <= w_wr_state_nxt;
            if (w_wr_accept) r_wbuf_valid <= 1'b1;
            if (r_wr_state == W_AW && awready) r_cnt <= 2'd0;
            if (wvalid && wready) r_cnt <= r_cnt + 2'd1;
            if (r_wr_state == W_RESP && bvalid) begin
                r_wbuf_valid <= 1'b0;
                r_cnt        <= 2'd0;
            end
        end
    end

    // Request payload only moves on acceptance, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_rd_accept) begin
            r_rd_addr <= rd_addr;
            r_rd_type <= rd_type;
        end
        if (w_wr_accept) begin
            r_wr_addr <= wr_addr;
            r_wr_type <= wr_type;
            r_wr_strb <= wr_wstrb;
            r_wr_buf  <= wr_data;
        end
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: scripted AXI slave with scoreboards on
// the cache return path and the AXI W channel.
module tb_cache_axi_bridge;
    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req, rd_rdy, ret_valid;
    logic [3:0]   rd_type;
    logic [31:0]  rd_addr, ret_data;
    logic [1:0]   ret_last;
    logic         wr_req, wr_rdy;
    logic [3:0]   wr_type, wr_wstrb;
    logic [31:0]  wr_addr;
    logic [127:0] wr_data;
    logic [3:0]   arid, awid, wid, rid, bid, wstrb;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst, rresp, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_pass = 0;
    int n_total = 0;

    logic [32:0] exp_ret[$];
    logic [36:0] exp_w[$];
    logic [32:0] e_ret;
    logic [36:0] e_w;

    always #5 clk = ~clk;

    cache_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always @(negedge clk) begin
        if (ret_valid === 1'b1) begin
            n_total++;
            if (exp_ret.size() == 0) begin
                $display("FAIL ret_unexpected: got data=%h last=%b, required no beat", ret_data, ret_last);
            end else begin
                e_ret = exp_ret.pop_front();
                if ({ret_last, ret_data} !== {1'b0, e_ret})
                    $display("FAIL ret_beat: got last=%b data=%h, required last=%b data=%h",
                             ret_last, ret_data, {1'b0, e_ret[32]}, e_ret[31:0]);
                else n_pass++;
            end
        end
        if (wvalid === 1'b1 && wready === 1'b1) begin
            n_total++;
            if (exp_w.size() == 0) begin
                $display("FAIL w_unexpected: got data=%h strb=%h last=%b, required no beat", wdata, wstrb, wlast);
            end else begin
                e_w = exp_w.pop_front();
                if ({wid, wdata, wstrb, wlast} !== {4'd0, e_w})
                    $display("FAIL w_beat: got id=%h data=%h strb=%h last=%b, required id=0 data=%h strb=%h last=%b",
                             wid, wdata, wstrb, wlast, e_w[36:5], e_w[4:1], e_w[0]);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_line_w(input logic [127:0] d);
        for (int i = 0; i < 4; i++) exp_w.push_back({d[32*i +: 32], 4'hf, (i == 3)});
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        sample();
        n_total++;
        if ({arvalid, awvalid, wvalid, ret_valid, rready, bready, ret_last} !== 8'b0)
            $display("FAIL reset_outputs: got %b, required 00000000",
                     {arvalid, awvalid, wvalid, ret_valid, rready, bready, ret_last});
        else n_pass++;
        tick();
        resetn = 1'b1;
        sample();
        n_total++;
        if ({rd_rdy, wr_rdy} !== 2'b11) $display("FAIL reset_ready: got %b, required 11", {rd_rdy, wr_rdy});
        else n_pass++;
    endtask

    task automatic test_line_read();
        logic [31:0] beats [5];
        beats = '{32'h11, 32'h22, 32'h0, 32'h33, 32'h44};
        tick();
        rd_req = 1'b1; rd_type = 4'd4; rd_addr = 32'h1C000040;
        sample();
        n_total++;
        if (rd_rdy !== 1'b1) $display("FAIL line_rd_rdy: got %b, required 1", rd_rdy); else n_pass++;
        tick();
        rd_req = 1'b0; rd_type = 4'd0; rd_addr = 32'hFFFFFFF0;
        for (int c = 0; c < 2; c++) begin
            sample();
            n_total++;
            if ({arvalid, araddr, arlen, arsize, arburst, arid} !== {1'b1, 32'h1C000040, 8'd3, 3'd2, 2'b01, 4'd0})
                $display("FAIL line_ar_%0d: got %h, required %h", c,
                         {arvalid, araddr, arlen, arsize, arburst, arid},
                         {1'b1, 32'h1C000040, 8'd3, 3'd2, 2'b01, 4'd0});
            else n_pass++;
            tick();
        end
        arready = 1'b1;
        sample();
        tick();
        arready = 1'b0;
        for (int i = 0; i < 5; i++) if (i != 2) exp_ret.push_back({(i == 4), beats[i]});
        for (int i = 0; i < 5; i++) begin
            rvalid = (i != 2); rdata = (i == 2) ? 32'hDEADBEEF : beats[i]; rlast = (i == 4);
            sample();
            n_total++;
            if ({rready, arvalid} !== 2'b10) $display("FAIL line_rready_%0d: got %b, required 10", i, {rready, arvalid});
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if (ret_valid !== 1'b0) $display("FAIL line_gap: got ret_valid=%b, required 0", ret_valid);
                else n_pass++;
            end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        n_total++;
        if (exp_ret.size() != 0) $display("FAIL line_rd_beats: got %0d missing, required 0", exp_ret.size());
        else n_pass++;
        sample();
        n_total++;
        if ({rd_rdy, ret_valid, rready} !== 3'b100)
            $display("FAIL line_rd_done: got %b, required 100", {rd_rdy, ret_valid, rready});
        else n_pass++;
    endtask

    task automatic test_line_write();
        int pat [5];
        pat = '{1, 0, 1, 1, 1};
        tick();
        wr_req = 1'b1; wr_type = 4'd4; wr_addr = 32'h00001230; wr_wstrb = 4'h0;
        wr_data = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        sample();
        n_total++;
        if (wr_rdy !== 1'b1) $display("FAIL line_wr_rdy: got %b, required 1", wr_rdy); else n_pass++;
        tick();
        push_line_w(wr_data);
        wr_req = 1'b0; wr_data = '0; wr_addr = '0;
        sample();
        n_total++;
        if ({awvalid, awaddr, awlen, awsize, awburst, awid, wr_rdy} !== {1'b1, 32'h1230, 8'd3, 3'd2, 2'b01, 4'd0, 1'b0})
            $display("FAIL line_aw: got %h, required %h", {awvalid, awaddr, awlen, awsize, awburst, awid, wr_rdy},
                     {1'b1, 32'h1230, 8'd3, 3'd2, 2'b01, 4'd0, 1'b0});
        else n_pass++;
        tick();
        awready = 1'b1;
        sample();
        tick();
        awready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wready = pat[i][0];
            sample();
            n_total++;
            if ({wvalid, wr_rdy} !== 2'b10) $display("FAIL line_wvalid_%0d: got %b, required 10", i, {wvalid, wr_rdy});
            else n_pass++;
            tick();
        end
        wready = 1'b0;
        n_total++;
        if (exp_w.size() != 0) $display("FAIL line_w_beats: got %0d missing, required 0", exp_w.size());
        else n_pass++;
        sample();
        n_total++;
        if ({bready, wvalid, wr_rdy} !== 3'b100) $display("FAIL line_wresp: got %b, required 100", {bready, wvalid, wr_rdy});
        else n_pass++;
        tick();
        bvalid = 1'b1;
        sample();
        n_total++;
        if (wr_rdy !== 1'b0) $display("FAIL line_wr_busy_b: got %b, required 0", wr_rdy); else n_pass++;
        tick();
        bvalid = 1'b0;
        sample();
        n_total++;
        if ({wr_rdy, bready} !== 2'b10) $display("FAIL line_wr_free: got %b, required 10", {wr_rdy, bready});
        else n_pass++;
    endtask

    task automatic test_word_write();
        tick();
        wr_req = 1'b1; wr_type = 4'd2; wr_addr = 32'hBFAF8000; wr_wstrb = 4'b0110;
        wr_data = {32'h99999999, 32'h88888888, 32'h77777777, 32'h12345678};
        tick();
        wr_req = 1'b0; wr_wstrb = 4'hf;
        exp_w.push_back({32'h12345678, 4'b0110, 1'b1});
        sample();
        n_total++;
        if ({awvalid, awaddr, awlen, awsize, awburst} !== {1'b1, 32'hBFAF8000, 8'd0, 3'd2, 2'b01})
            $display("FAIL word_aw: got %h, required %h", {awvalid, awaddr, awlen, awsize, awburst},
                     {1'b1, 32'hBFAF8000, 8'd0, 3'd2, 2'b01});
        else n_pass++;
        awready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b1;
        sample();
        tick();
        wready = 1'b0;
        n_total++;
        if (exp_w.size() != 0) $display("FAIL word_w_beats: got %0d missing, required 0", exp_w.size());
        else n_pass++;
        sample();
        n_total++;
        if ({wvalid, bready} !== 2'b01) $display("FAIL word_single: got %b, required 01", {wvalid, bready});
        else n_pass++;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        sample();
        n_total++;
        if (wr_rdy !== 1'b1) $display("FAIL word_wr_free: got %b, required 1", wr_rdy); else n_pass++;
    endtask

    task automatic test_raw();
        tick();
        wr_req = 1'b1; wr_type = 4'd4; wr_addr = 32'h00002000;
        wr_data = {32'h40404040, 32'h30303030, 32'h20202020, 32'h10101010};
        tick();
        wr_req = 1'b0;
        push_line_w(wr_data);
        awready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b1;
        repeat (4) tick();
        wready = 1'b0;
        rd_req = 1'b1; rd_type = 4'd2; rd_addr = 32'h00002000;
        for (int i = 0; i < 10; i++) begin
            sample();
            n_total++;
            if (rd_rdy !== 1'b0) $display("FAIL raw_same_block_%0d: got %b, required 0", i, rd_rdy); else n_pass++;
            tick();
        end
        bvalid = 1'b1;
        sample();
        n_total++;
        if (rd_rdy !== 1'b0) $display("FAIL raw_same_at_b: got %b, required 0", rd_rdy); else n_pass++;
        tick();
        bvalid = 1'b0;
        sample();
        n_total++;
        if (rd_rdy !== 1'b1) $display("FAIL raw_same_release: got %b, required 1", rd_rdy); else n_pass++;
        tick();
        rd_req = 1'b0;
        arready = 1'b1;
        sample();
        n_total++;
        if ({arvalid, araddr, arlen, arsize} !== {1'b1, 32'h00002000, 8'd0, 3'd2})
            $display("FAIL raw_ar: got %h, required %h", {arvalid, araddr, arlen, arsize}, {1'b1, 32'h00002000, 8'd0, 3'd2});
        else n_pass++;
        tick();
        arready = 1'b0;
        exp_ret.push_back({1'b1, 32'h5555AAAA});
        rvalid = 1'b1; rdata = 32'h5555AAAA; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;

        wr_req = 1'b1; wr_addr = 32'h00002000;
        wr_data = {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};
        tick();
        wr_req = 1'b0;
        push_line_w(wr_data);
        rd_req = 1'b1; rd_type = 4'd2; rd_addr = 32'h00003000;
        sample();
`ifdef CACHE_BRIDGE_RAW_ADDR_CMP_EN
        n_total++;
        if (rd_rdy !== 1'b1) $display("FAIL raw_other_line: got %b, required 1", rd_rdy); else n_pass++;
        tick();
        rd_req = 1'b0;
        arready = 1'b1; awready = 1'b1;
        sample();
        n_total++;
        if ({arvalid, awvalid} !== 2'b11) $display("FAIL raw_concurrent: got %b, required 11", {arvalid, awvalid});
        else n_pass++;
        tick();
        arready = 1'b0; awready = 1'b0;
        exp_ret.push_back({1'b1, 32'h00000077});
        rvalid = 1'b1; rdata = 32'h77; rlast = 1'b1; wready = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        repeat (3) tick();
        wready = 1'b0;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
`else
        n_total++;
        if (rd_rdy !== 1'b0) $display("FAIL raw_other_line: got %b, required 0", rd_rdy); else n_pass++;
        awready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b1;
        repeat (4) tick();
        wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_total++;
            if (rd_rdy !== 1'b0) $display("FAIL raw_other_block_%0d: got %b, required 0", i, rd_rdy); else n_pass++;
            tick();
        end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        sample();
        n_total++;
        if (rd_rdy !== 1'b1) $display("FAIL raw_other_release: got %b, required 1", rd_rdy); else n_pass++;
        tick();
        rd_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        exp_ret.push_back({1'b1, 32'h00000077});
        rvalid = 1'b1; rdata = 32'h77; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
`endif
        n_total++;
        if (exp_ret.size() + exp_w.size() != 0)
            $display("FAIL raw_beats: got %0d missing, required 0", exp_ret.size() + exp_w.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        tick();
        rd_req = 1'b1; rd_type = 4'd2; rd_addr = 32'h00000040;
        wr_req = 1'b1; wr_type = 4'd2; wr_addr = 32'h00000044; wr_wstrb = 4'hf;
        wr_data = {96'h0, 32'hCAFE0001};
        sample();
        n_total++;
        if ({rd_rdy, wr_rdy} !== 2'b11) $display("FAIL b2b_ready: got %b, required 11", {rd_rdy, wr_rdy}); else n_pass++;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        exp_w.push_back({32'hCAFE0001, 4'hf, 1'b1});
        sample();
        n_total++;
        if ({arvalid, awvalid, araddr, awaddr} !== {2'b11, 32'h40, 32'h44})
            $display("FAIL b2b_issued: got %h, required %h", {arvalid, awvalid, araddr, awaddr}, {2'b11, 32'h40, 32'h44});
        else n_pass++;
        arready = 1'b1; awready = 1'b1;
        tick();
        arready = 1'b0; awready = 1'b0;
        exp_ret.push_back({1'b1, 32'hBEEF0002});
        rvalid = 1'b1; rdata = 32'hBEEF0002; rlast = 1'b1; wready = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0; wready = 1'b0;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        n_total++;
        if (exp_ret.size() + exp_w.size() != 0)
            $display("FAIL b2b_beats: got %0d missing, required 0", exp_ret.size() + exp_w.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        tick();
        rd_req = 1'b1; rd_type = 4'd4; rd_addr = 32'h00000100;
        tick();
        rd_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 4; i++) exp_ret.push_back({(i == 3), 32'h100 + 32'(i)});
        for (int i = 0; i < 2; i++) begin
            rvalid = 1'b1; rdata = 32'h100 + 32'(i); rlast = 1'b0;
            tick();
        end
        rvalid = 1'b0;
        resetn = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h102;
        n_total++;
        if (exp_ret.size() != 2) $display("FAIL mid_reset_beats: got %0d left, required 2", exp_ret.size());
        else n_pass++;
        sample();
        n_total++;
        if ({rready, ret_valid, arvalid} !== 3'b000)
            $display("FAIL mid_reset_outputs: got %b, required 000", {rready, ret_valid, arvalid});
        else n_pass++;
        tick();
        rvalid = 1'b0;
        resetn = 1'b1;
        exp_ret.delete();
        sample();
        n_total++;
        if ({rd_rdy, wr_rdy} !== 2'b11) $display("FAIL mid_reset_ready: got %b, required 11", {rd_rdy, wr_rdy});
        else n_pass++;
    endtask

    initial begin
        resetn = 1'b0;
        rd_req = 1'b0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;
        test_reset();
        test_line_read();
        test_line_write();
        test_word_write();
        test_raw();
        test_back_to_back();
        test_reset_mid_burst();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Memory-side responder for the cache's refill/writeback interface (rd_req/ret_*, wr_req/wr_rdy).
- Converts each cache request into one AXI4 master transaction: line read = 4-beat INCR burst; line write = 4-beat burst from a 128-bit write buffer; byte/half/word types = single-beat.
- Sits between one cache instance and the AXI interconnect.
- Read and write channels run concurrently, subject to the read-after-write (RAW) rule below.

Parameters:
- ID, default 4'd0, value driven on arid/awid/wid.
- ADDR_W, default 32, address width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- rd_req  in  1  cache read request
- rd_type  in  4  0=byte, 1=half, 2=word, 4=line
- rd_addr  in  32  read start address
- rd_rdy  out  1  read request accepted this cycle
- ret_valid  out  1  read beat valid
- ret_last  out  2  {1'b0, last beat}
- ret_data  out  32  read beat data
- wr_req  in  1  cache write request
- wr_type  in  4  encoding as rd_type
- wr_addr  in  32  write start address
- wr_wstrb  in  4  byte mask (non-line types only)
- wr_data  in  128  line data, word0 in [31:0]
- wr_rdy  out  1  write buffer free
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI AR
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI R
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI AW
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI W
- wready  in  1
- bid/bresp/bvalid  in  4/2/1  AXI B
- bready  out  1

Behaviour:
- Reset (resetn=0 at a clk edge): both FSMs go to IDLE; arvalid, awvalid, wvalid, rready, bready, ret_valid = 0; ret_last = 0; beat counter = 0; write buffer valid = 0.
- Reset mid-transaction abandons the AXI transaction; the interconnect is reset together with the bridge.
- Length/size encoding:
  - Line type: len = 3, size = 2.
  - Other types: len = 0, size = type[1:0].
  - burst = 2'b01 (INCR) always.
  - Line addresses are forwarded unchanged; the cache supplies offset 0.
- Read FSM: R_IDLE -> R_AR -> R_DATA -> R_IDLE.
  - rd_rdy = (state==R_IDLE) & ~raw_block.
  - Request accepted on rd_req & rd_rdy: latch addr/type, enter R_AR next cycle.
  - R_AR: arvalid=1 with latched fields; on arready go to R_DATA.
  - R_DATA: rready=1; ret_valid=rvalid; ret_data=rdata; ret_last={1'b0,rlast}, combinational pass-through (zero added latency).
  - rvalid & rlast returns the FSM to R_IDLE.
  - rresp is ignored.
- Write FSM: W_IDLE -> W_AW -> W_DATA -> W_RESP -> W_IDLE.
  - wr_rdy = (state==W_IDLE), registered-stable, high before any wr_req is honoured.
  - On wr_req & wr_rdy: latch addr, type, strb, 128-bit data; buffer valid = 1.
  - W_AW: awvalid=1; on awready go to W_DATA with cnt=0.
  - W_DATA: wvalid=1; wdata=buf[32*cnt+:32]; wstrb=4'hf for line, else latched wr_wstrb; wlast=(cnt==awlen).
  - Each wvalid & wready increments cnt (2-bit, wraps at 3). Handshake with wlast goes to W_RESP.
  - W_RESP: bready=1; bvalid returns to W_IDLE, clears buffer valid, cnt=0. bresp is ignored.
- RAW hazard: raw_block is high while buffer valid and the pending write is not yet acknowledged by B; scope per Optional Feature.
- AXI rules:
  - valid stays high until its handshake; payload is stable while valid.
  - AR and AW may be outstanding in the same cycle.
  - At most one read and one write are in flight.
- A simultaneous rd_req and wr_req in one cycle are both accepted if neither is blocked.
  - raw_block for that read uses the buffer state before this cycle's write acceptance, so the read is not blocked.
  - Ordering is the cache's responsibility: the cache issues the write first.

Optional Feature:
- Macro: CACHE_BRIDGE_RAW_ADDR_CMP_EN.
- Defined: raw_block = buffer valid & (rd_addr[31:4] == buffered wr_addr[31:4]). Reads to other lines proceed during a writeback.
- Undefined: raw_block = buffer valid. Any read stalls until the write's B response.

Test Plan:
- Reset check: hold resetn=0 for 3 cycles -> arvalid=awvalid=wvalid=ret_valid=0; rd_rdy=wr_rdy=1 after release.
- Line read: rd_req, type 4, addr 0x1C000040; arready after 2 cycles; R beats 0x11,0x22,0x33,0x44 with rlast on the 4th -> araddr=0x1C000040, arlen=3, arsize=2, arburst=1; ret_valid on exactly those 4 cycles; ret_last=2'b01 only on 0x44; rd_rdy=1 the cycle after.
- Line write: wr_data=0xDDDD..CCCC..BBBB..AAAA, addr 0x00001230; wready toggling 1,0,1,1,1 -> awlen=3; beats 0xAAAAAAAA..0xDDDDDDDD in order; wlast on the 4th; wr_rdy=0 until bvalid, then 1.
- Word write: type 2, wstrb 4'b0110, addr 0xBFAF8000 -> awlen=0, awsize=2, single beat, wstrb=4'b0110, wlast=1.
- RAW: write pending to 0x00002000 with bvalid delayed 10 cycles.
  - Read 0x00002000 -> rd_rdy=0 until the cycle after bvalid.
  - Read 0x00003000 -> accepted immediately (macro defined) or stalled (macro undefined).
- Reset mid-burst: resetn=0 after the 2nd R beat -> next cycle rready=0, ret_valid=0, rd_rdy=1 after release.
